// File: rtl/nibble_serializer.sv
// Parallel-to-nibble serializer: loads a DEPTH-nibble word and emits it LSB nibble first,
// advancing one nibble per clock-enable cycle, with Ready/Load and Valid/Last handshakes.
module nibble_serializer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Ce,
    input  logic               Load,
    input  logic [4*DEPTH-1:0] Din,
    output logic               Ready,
    output logic [3:0]         Dout,
    output logic               Valid,
    output logic               Last,
    output logic [2:0]         Cnt
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [2:0] LastIdx = 3'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [4*DEPTH-1:0] shift_q, shift_d;
    logic [3:0]         dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         cnt_inc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            shift_q <= '0;
            dout_q  <= 4'h0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 3'd1;

        // Ready also covers the cycle the final nibble is consumed, enabling reload with no bubble.
        Ready = (state_q == StIdle) || ((state_q == StShift) && last_q && Ce);

        if (Load && Ready) begin
            // The shift register keeps only the nibbles still to be presented after Din[3:0].
            state_d = StShift;
            shift_d = Din >> 4;
            dout_d  = Din[3:0];
            cnt_d   = 3'd0;
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if ((state_q == StShift) && Ce) begin
            if (last_q) begin
                state_d = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
                cnt_d   = 3'd0;
            end else begin
                shift_d = shift_q >> 4;
                dout_d  = shift_q[3:0];
                cnt_d   = cnt_inc;
                last_d  = (cnt_inc == LastIdx);
            end
        end
    end

    assign Dout  = dout_q;
    assign Valid = valid_q;
    assign Last  = last_q;
    assign Cnt   = cnt_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: directed vector table, hand-written reset and
// DEPTH=2 sequences, and randomized traffic against a word/index reference model.
module tb_nibble_serializer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ce = 1'b0, load = 1'b0;
    logic [15:0] din = '0;
    logic        ready, valid, last;
    logic [3:0]  dout;
    logic [2:0]  cnt;

    logic        ce2 = 1'b0, load2 = 1'b0;
    logic [7:0]  din2 = '0;
    logic        ready2, valid2, last2;
    logic [3:0]  dout2;
    logic [2:0]  cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    nibble_serializer #(.DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .Ce(ce), .Load(load), .Din(din),
        .Ready(ready), .Dout(dout), .Valid(valid), .Last(last), .Cnt(cnt)
    );

    nibble_serializer #(.DEPTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .Ce(ce2), .Load(load2), .Din(din2),
        .Ready(ready2), .Dout(dout2), .Valid(valid2), .Last(last2), .Cnt(cnt2)
    );

    typedef struct {
        logic        ld;
        logic        c;
        logic [15:0] d;
        logic        e_ready;  // before the edge
        logic        e_valid;  // after the edge
        logic [3:0]  e_dout;
        logic        e_last;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic ld, input logic c, input logic [15:0] d, input logic r,
                       input logic v, input logic [3:0] o, input logic l, input logic [2:0] n);
        vec_t x;
        x.ld = ld; x.c = c; x.d = d; x.e_ready = r;
        x.e_valid = v; x.e_dout = o; x.e_last = l; x.e_cnt = n;
        vecs.push_back(x);
    endtask

    // Drive at negedge, sample Ready just after, then sample registered outputs 1 after posedge.
    logic s_ready;
    task automatic step(input logic ld, input logic c, input logic [15:0] d);
        @(negedge CLK);
        load = ld; ce = c; din = d;
        #1 s_ready = ready;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: the word in flight and which nibble index is presented.
    logic [15:0] m_word;
    int          m_idx;
    bit          m_busy;

    initial begin
        logic exp_rdy;
        logic ld, c;
        logic [15:0] d;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", last, 0);
        chk("rst_cnt", cnt, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1 chk("rst_ready", ready, 1);

        // ready valid dout last cnt
        add(1, 1, 16'hA5C3, 1, 1, 4'h3, 0, 0);
        add(0, 1, 16'h0000, 0, 1, 4'hC, 0, 1);
        add(0, 1, 16'h0000, 0, 1, 4'h5, 0, 2);
        add(0, 1, 16'h0000, 0, 1, 4'hA, 1, 3);
        add(0, 1, 16'h0000, 1, 0, 4'h0, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 4'h0, 0, 0);
        // Ce gating, load with Ce=0
        add(1, 0, 16'h1234, 1, 1, 4'h4, 0, 0);
        add(0, 1, 16'h0000, 0, 1, 4'h3, 0, 1);
        add(0, 0, 16'h0000, 0, 1, 4'h3, 0, 1);
        add(0, 0, 16'h0000, 0, 1, 4'h3, 0, 1);
        add(0, 1, 16'h0000, 0, 1, 4'h2, 0, 2);
        add(0, 0, 16'h0000, 0, 1, 4'h2, 0, 2);
        add(0, 1, 16'h0000, 0, 1, 4'h1, 1, 3);
        add(0, 0, 16'h0000, 0, 1, 4'h1, 1, 3);
        add(0, 1, 16'h0000, 1, 0, 4'h0, 0, 0);
        // Back-to-back reload
        add(1, 1, 16'hFEDC, 1, 1, 4'hC, 0, 0);
        add(0, 1, 16'h0000, 0, 1, 4'hD, 0, 1);
        add(0, 1, 16'h0000, 0, 1, 4'hE, 0, 2);
        add(0, 1, 16'h0000, 0, 1, 4'hF, 1, 3);
        add(1, 1, 16'h0987, 1, 1, 4'h7, 0, 0);
        add(0, 1, 16'h0000, 0, 1, 4'h8, 0, 1);
        add(0, 1, 16'h0000, 0, 1, 4'h9, 0, 2);
        add(0, 1, 16'h0000, 0, 1, 4'h0, 1, 3);
        add(0, 1, 16'h0000, 1, 0, 4'h0, 0, 0);
        // Ignored load while busy
        add(1, 1, 16'h4321, 1, 1, 4'h1, 0, 0);
        add(0, 1, 16'h0000, 0, 1, 4'h2, 0, 1);
        add(1, 1, 16'hBBBB, 0, 1, 4'h3, 0, 2);
        add(1, 0, 16'hBBBB, 0, 1, 4'h3, 0, 2);
        add(0, 1, 16'h0000, 0, 1, 4'h4, 1, 3);
        add(0, 1, 16'h0000, 1, 0, 4'h0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].c, vecs[i].d);
            chk($sformatf("vec%0d_ready", i), s_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
            if (vecs[i].e_valid) chk($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
            chk($sformatf("vec%0d_last", i), last, vecs[i].e_last);
            chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].e_cnt);
        end

        // Asynchronous reset mid-word, with Load held during reset
        step(1, 1, 16'h4321);
        step(0, 1, 16'h0000);
        chk("mid_dout_before", dout, 4'h2);
        #2 RST = 1'b0;
        #1;
        chk("async_valid", valid, 0);
        chk("async_dout", dout, 0);
        chk("async_last", last, 0);
        chk("async_cnt", cnt, 0);
        @(negedge CLK);
        load = 1'b1; din = 16'hFFFF; ce = 1'b1;
        @(posedge CLK);
        #1 chk("rst_load_valid", valid, 0);
        @(negedge CLK);
        RST = 1'b1; load = 1'b0;
        #1 chk("post_rst_ready", ready, 1);
        @(posedge CLK);
        #1 chk("post_rst_idle", valid, 0);

        // DEPTH=2 instance
        @(negedge CLK);
        load2 = 1'b1; din2 = 8'h5A; ce2 = 1'b1;
        #1 chk("d2_ready", ready2, 1);
        @(posedge CLK);
        #1;
        chk("d2_dout0", dout2, 4'hA);
        chk("d2_last0", last2, 0);
        chk("d2_valid0", valid2, 1);
        @(negedge CLK);
        load2 = 1'b0;
        @(posedge CLK);
        #1;
        chk("d2_dout1", dout2, 4'h5);
        chk("d2_last1", last2, 1);
        chk("d2_cnt1", cnt2, 1);
        @(posedge CLK);
        #1 chk("d2_valid_end", valid2, 0);
        ce2 = 1'b0;

        // Randomized traffic vs reference model (DUT is idle here)
        m_busy = 0; m_idx = 0; m_word = '0;
        for (int t = 0; t < 3000; t++) begin
            ld = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 9) < 7);
            d  = 16'($urandom);
            exp_rdy = !m_busy || (m_idx == 3 && c);
            step(ld, c, d);
            chk("rnd_ready", s_ready, exp_rdy);
            if (ld && exp_rdy) begin
                m_word = d; m_idx = 0; m_busy = 1;
            end else if (m_busy && c) begin
                if (m_idx == 3) m_busy = 0;
                else m_idx++;
            end
            chk("rnd_valid", valid, m_busy);
            if (m_busy) chk("rnd_dout", dout, (m_word >> (4 * m_idx)) & 16'hF);
            chk("rnd_last", last, m_busy && m_idx == 3);
            chk("rnd_cnt", cnt, m_busy ? m_idx : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_serializer.md
Name: nibble_serializer

Overview:
- Transmit-side counterpart of the 4-bit registered nibble pipeline.
- Accepts one parallel word of DEPTH nibbles, then emits it one 4-bit nibble at a time, least-significant nibble first.
- Each output nibble advances only on a clock-enable (Ce) cycle, so downstream Ce-gated nibble registers consume exactly one nibble per enabled cycle.
- Provides a Ready/Load handshake on the parallel side and Valid/Last flags on the nibble side.

Parameters:
- DEPTH, 4, number of nibbles per parallel word; legal range 2..8; Din width is 4*DEPTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-low reset.
- Ce  input  1  advance enable; the current nibble is consumed on a CLK edge with Ce=1.
- Load  input  1  load request for Din; honoured only when Ready=1.
- Din  input  4*DEPTH  parallel word; nibble k is Din[4k+3:4k].
- Ready  output  1  combinational; block can accept Load this cycle.
- Dout  output  4  current nibble, registered.
- Valid  output  1  Dout holds a nibble not yet consumed, registered.
- Last  output  1  Dout is nibble DEPTH-1 of the word, registered.
- Cnt  output  3  index of the nibble currently on Dout, registered.

Behaviour:
- Reset (RST=0, asynchronous, any time):
  - State=IDLE, shift register=0, Dout=0, Valid=0, Last=0, Cnt=0.
  - Ready=1 once RST is released.
  - A word in flight is discarded; no partial output after reset.
- States: IDLE and SHIFT.
- Ready = (state==IDLE) OR (state==SHIFT AND Last AND Ce).
- Loading:
  - Load=1 AND Ready=1 at a CLK edge captures Din. Ce is not required for the load itself.
  - Next cycle: state=SHIFT, Dout=Din[3:0], Cnt=0, Valid=1, Last=0.
  - Latency from load to first nibble on Dout: 1 cycle.
- SHIFT, Ce=0: all outputs and state hold; Dout is stable indefinitely.
- SHIFT, Ce=1, Cnt<DEPTH-1:
  - Shift register moves right by 4 bits; Dout = next nibble; Cnt += 1.
  - Last=1 when the new Cnt equals DEPTH-1.
- SHIFT, Ce=1, Last=1 (final nibble consumed):
  - If Load=1: back-to-back reload, treated exactly as a load from IDLE. Next cycle Dout = new Din[3:0], Cnt=0, Valid=1, Last=0, with no bubble.
  - Else: state=IDLE, Valid=0, Last=0, Cnt=0. Dout holds its last value and is don't-care while Valid=0.
- Load=1 while Ready=0 is ignored; Din is not sampled and the word in flight is not corrupted.
- In IDLE, Ce is ignored.
- Nibbles of any word are emitted in order 0..DEPTH-1 with none skipped or repeated.
- Cnt never exceeds DEPTH-1. Wrap-around occurs only through the IDLE or reload path.
- Simultaneous RST=0 and Load=1: reset wins; nothing is loaded.
- Throughput: with Ce held at 1 and Load asserted at every Ready, one nibble per cycle, DEPTH cycles per word.

Test Plan:
- Reset and single word, Ce=1:
  - Stimulus: assert RST=0 for 2 cycles, release, then Load with Din=16'hA5C3 and Ce tied 1.
  - Response: Dout sequence 3,C,5,A on consecutive cycles; Last=1 only with A; Valid falls the cycle after A; Ready=1 again.
- Ce gating:
  - Stimulus: load 16'h1234, then drive Ce pattern 1,0,0,1,0,1,1.
  - Response: Dout=4 persists until the first Ce edge, then 3 held for 3 cycles, then 2, then 1; Cnt follows 0,1,1,1,2,2,3.
- Back-to-back:
  - Stimulus: Ce=1, load 16'hFEDC, then assert Load with 16'h0987 in the cycle Last=1.
  - Response: Dout C,D,E,F,7,8,9,0 with no gap; Valid stays 1 throughout.
- Ignored load:
  - Stimulus: during the second nibble of 16'h4321, pulse Load with 16'hBBBB.
  - Response: output remains 1,2,3,4; no B nibble appears.
- Reset mid-word:
  - Stimulus: assert RST=0 asynchronously, between edges, while Dout=2 of 16'h4321.
  - Response: Valid, Dout, Last and Cnt go to 0 immediately without waiting for a clock edge; after release, Ready=1 and no stale nibbles appear.
- DEPTH=2 build:
  - Stimulus: load 8'h5A with Ce=1.
  - Response: Dout A then 5; Last=1 on the second nibble.
